cascaded_down_timer: RTL and testbench
======================================

// Module: cascaded_down_timer
// PURPOSE
//  Parametrised multi-digit down-counter built from cascaded per-digit mod-M counters.
//  Default shape is an MM:SS countdown timer (digit moduli 6/10/6/10) for the display/timer path.
//  Adds to the single mod-10 digit counter: N digits, per-digit modulus, borrow cascade,
//  load clamping, a saturate-or-wrap mode and a one-cycle done pulse.
// PARAMETERS
//  DIGITS    4         number of 4-bit digits (1..8)
//  MODULI    16'h6A6A  packed 4 bits per digit, digit 0 in [3:0]; each value 2..10
//  SATURATE  1         1: hold at all-zero; 0: wrap all-zero -> all (M-1)
// PORTS
//  clk        in   1          rising-edge clock
//  clear      in   1          asynchronous reset, active-high
//  load_n     in   1          synchronous parallel load, active-low
//  enable     in   1          count-down strobe, one decrement per enabled cycle
//  data       in   4*DIGITS   load value, digit i in [4i+3:4i]
//  count      out  4*DIGITS   current value, digit i in [4i+3:4i]
//  count_end  out  1          high while every digit is zero
//  done_pulse out  1          one-cycle pulse when a decrement reaches all-zero
// BEHAVIOUR
//  - Reset (clear=1, async): count=0, done_pulse=0, count_end=1. Reset mid-count aborts at once.
//  - Priority at each clk edge: clear > load > enable > hold.
//  - Load (load_n=0): count <= data next edge, regardless of enable.
//    Each loaded digit >= its modulus is clamped to modulus-1. Loading does not raise done_pulse.
//  - Decrement (enable=1, load_n=1): digit 0 always steps.
//    Digit i>0 steps only when digits 0..i-1 are all zero (combinational borrow chain).
//    A stepping digit at 0 wraps to M_i-1; any other digit value v becomes v-1.
//  - All-zero with enable=1: SATURATE=1 holds count at zero with no pulse.
//    SATURATE=0 wraps to every digit at M_i-1 with no pulse.
//  - count_end: combinational decode of the count register (zero latency), =1 iff count==0.
//  - done_pulse: registered, high for exactly the one cycle following the edge where a
//    decrement moved count from nonzero to zero; low after load, clear or hold.
//  - enable held low: count is stable indefinitely. load_n and enable are sampled synchronously only.
//  - Digit arithmetic is 4-bit unsigned; no digit ever exceeds M_i-1.
// STRUCTURE
//  - Shared package timer_pkg: DIGIT_W=4, default moduli constant MMSS_MODULI=16'h6A6A,
//    and a function clamp_digit(value, modulus).
//  - Sub-module digit_down_counter (MOD param): inputs clk, clear, load_n, enable,
//    borrow_in, data[3:0]; outputs q[3:0] and is_zero.
//    The top instantiates DIGITS of these via generate and chains
//    borrow_in[i] = enable & &is_zero[i-1:0].
//  - The top also holds the done_pulse register and the count_end reduction.
// TESTING
//  1. Assert clear mid-count (count=16'h0345) -> count=0, count_end=1, done_pulse=0 with no clk edge.
//  2. load_n=0, data=16'h1200, then enable=1 for one cycle -> 16'h1200, then 16'h1159.
//  3. From 16'h0001 with enable=1 -> 16'h0000; done_pulse=1 for one cycle; count_end=1.
//  4. SATURATE=1 at 16'h0000 with enable=1 for 5 cycles -> count stays 0; done_pulse stays 0.
//     SATURATE=0 at 16'h0000 with enable=1 -> 16'h5959.
//  5. Load data=16'h7A9F -> clamped to 16'h5959; load_n=0 and enable=1 together -> load wins.
//  6. Full run: load 16'h0100, enable every cycle -> done_pulse exactly at cycle 60;
//     no digit ever exceeds its modulus.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants and helpers for the cascaded down-timer family.
package timer_pkg;

  localparam int DIGIT_W = 4;

  // Default MM:SS shape: digit 0 counts seconds units (mod 10), digit 1 tens
  // of seconds (mod 6), digit 2 minute units (mod 10), digit 3 tens (mod 6).
  localparam logic [15:0] MMSS_MODULI = 16'h6A6A;

  // Limit a loaded digit to the largest value its modulus allows.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] value,
                                                     input logic [DIGIT_W-1:0] modulus);
    return (value >= modulus) ? (modulus - DIGIT_W'(1)) : value;
  endfunction

endpackage

// File: rtl/digit_down_counter.sv
// One mod-MOD down-counting digit. It steps when both the global enable and
// its borrow input are high; a step from zero wraps to MOD-1.
module digit_down_counter
  import timer_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               load_n,
  input  logic               enable,
  input  logic               borrow_in,
  input  logic [DIGIT_W-1:0] data,
  output logic [DIGIT_W-1:0] q,
  output logic               is_zero
);

  localparam logic [DIGIT_W-1:0] MOD_V = DIGIT_W'(MOD);
  localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MOD - 1);

  // Digit register: clear, then clamped load, then borrow-gated decrement.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      q <= '0;
    end else if (!load_n) begin
      q <= clamp_digit(data, MOD_V);
    end else if (enable && borrow_in) begin
      q <= (q == '0) ? MAX_V : (q - DIGIT_W'(1));
    end
  end

  assign is_zero = (q == '0);

endmodule

// File: rtl/cascaded_down_timer.sv
// Multi-digit down counter built from cascaded per-digit counters, with a
// borrow chain, clamped load, saturate-or-wrap at zero and a done pulse.
module cascaded_down_timer
  import timer_pkg::*;
#(
  parameter int                  DIGITS   = 4,
  parameter logic [4*DIGITS-1:0] MODULI   = MMSS_MODULI,
  parameter bit                  SATURATE = 1'b1
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  load_n,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   data,
  output logic [4*DIGITS-1:0]   count,
  output logic                  count_end,
  output logic                  done_pulse
);

  logic [DIGITS-1:0] is_zero;
  logic [DIGITS-1:0] lower_zero;
  logic              step_en;
  logic              upper_zero;
  logic              final_step;

  assign count_end = &is_zero;

  // In saturate mode an all-zero count must not wrap, so the step is blocked
  // at the source rather than inside every digit.
  assign step_en = enable & ~(SATURATE & count_end);

  // Borrow chain: lower_zero[i] is high when every digit below i is zero.
  always_comb begin
    lower_zero    = '0;
    lower_zero[0] = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      lower_zero[i] = lower_zero[i-1] & is_zero[i-1];
    end
  end

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      digit_down_counter #(
        .MOD (int'(MODULI[4*g +: 4]))
      ) u_digit (
        .clk       (clk),
        .clear     (clear),
        .load_n    (load_n),
        .enable    (step_en),
        .borrow_in (step_en & lower_zero[g]),
        .data      (data[4*g +: 4]),
        .q         (count[4*g +: 4]),
        .is_zero   (is_zero[g])
      );
    end
  endgenerate

  // Detect a count of exactly one: the only value a decrement turns into zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      upper_zero = upper_zero & is_zero[i];
    end
  end

  assign final_step = (count[DIGIT_W-1:0] == DIGIT_W'(1)) & upper_zero;

  // Done pulse: high for the cycle after a decrement lands on zero.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= load_n & enable & final_step;
    end
  end

endmodule

// File: tb/tb_cascaded_down_timer.sv
// Scoreboard bench for cascaded_down_timer: a saturating and a wrapping
// instance share stimulus and are compared against a mixed-radix value model.
module tb_cascaded_down_timer;

  typedef struct packed {
    logic [15:0] cnt;
    logic        cend;
    logic        done;
  } exp_t;

  logic        clk;
  logic        clear;
  logic        load_n;
  logic        enable;
  logic [15:0] data;
  logic [15:0] count_sat, count_wrap;
  logic        cend_sat, cend_wrap;
  logic        done_sat, done_wrap;

  int checks = 0;
  int errors = 0;

  int   mods [4] = '{10, 6, 10, 6};
  int   total = 3600;
  int   val  [2];
  bit   done_m [2];
  exp_t exp_q_sat [$];
  exp_t exp_q_wrap [$];

  cascaded_down_timer #(.DIGITS(4), .MODULI(16'h6A6A), .SATURATE(1'b1)) dut_sat (
    .clk        (clk),
    .clear      (clear),
    .load_n     (load_n),
    .enable     (enable),
    .data       (data),
    .count      (count_sat),
    .count_end  (cend_sat),
    .done_pulse (done_sat)
  );

  cascaded_down_timer #(.DIGITS(4), .MODULI(16'h6A6A), .SATURATE(1'b0)) dut_wrap (
    .clk        (clk),
    .clear      (clear),
    .load_n     (load_n),
    .enable     (enable),
    .data       (data),
    .count      (count_wrap),
    .count_end  (cend_wrap),
    .done_pulse (done_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Digit pattern to mixed-radix integer, clamping out-of-range digits.
  function automatic int to_val(input logic [15:0] d);
    int v = 0;
    int w = 1;
    int dig;
    for (int i = 0; i < 4; i++) begin
      dig = int'(d[4*i +: 4]);
      if (dig >= mods[i]) dig = mods[i] - 1;
      v += dig * w;
      w *= mods[i];
    end
    return v;
  endfunction

  function automatic logic [15:0] to_digits(input int v);
    logic [15:0] r = '0;
    int rem = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(rem % mods[i]);
      rem = rem / mods[i];
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model and queue the expected result.
  task automatic applyStimulus(input bit ld, input logic [15:0] d, input bit en);
    exp_t e;
    @(negedge clk);
    load_n = ~ld;
    data   = d;
    enable = en;
    for (int s = 0; s < 2; s++) begin
      if (ld) begin
        val[s]    = to_val(d);
        done_m[s] = 1'b0;
      end else if (en) begin
        if (val[s] == 0) begin
          val[s]    = (s == 0) ? 0 : total - 1;
          done_m[s] = 1'b0;
        end else begin
          val[s]    = val[s] - 1;
          done_m[s] = (val[s] == 0);
        end
      end else begin
        done_m[s] = 1'b0;
      end
      e.cnt  = to_digits(val[s]);
      e.cend = (val[s] == 0);
      e.done = done_m[s];
      if (s == 0) exp_q_sat.push_back(e);
      else        exp_q_wrap.push_back(e);
    end
  endtask

  // Asynchronous clear between edges, checked before any clock edge occurs.
  task automatic applyClear();
    @(negedge clk);
    #2 clear = 1'b1;
    #1;
    checkOutput("clear_count_sat",  32'(count_sat),  32'h0);
    checkOutput("clear_cend_sat",   32'(cend_sat),   32'h1);
    checkOutput("clear_done_sat",   32'(done_sat),   32'h0);
    checkOutput("clear_count_wrap", 32'(count_wrap), 32'h0);
    checkOutput("clear_done_wrap",  32'(done_wrap),  32'h0);
    val[0] = 0; val[1] = 0;
    done_m[0] = 1'b0; done_m[1] = 1'b0;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Monitor: after every rising edge, compare outputs with the queued model state.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q_sat.size() > 0) begin
        e = exp_q_sat.pop_front();
        checkOutput("count_sat", 32'(count_sat), 32'(e.cnt));
        checkOutput("cend_sat",  32'(cend_sat),  32'(e.cend));
        checkOutput("done_sat",  32'(done_sat),  32'(e.done));
      end
      if (exp_q_wrap.size() > 0) begin
        e = exp_q_wrap.pop_front();
        checkOutput("count_wrap", 32'(count_wrap), 32'(e.cnt));
        checkOutput("cend_wrap",  32'(cend_wrap),  32'(e.cend));
        checkOutput("done_wrap",  32'(done_wrap),  32'(e.done));
      end
      for (int i = 0; i < 4; i++) begin
        if (int'(count_sat[4*i +: 4]) >= mods[i] || int'(count_wrap[4*i +: 4]) >= mods[i]) begin
          errors++;
          $display("[TB] FAIL digit_range: digit %0d got %0h/%0h, limit %0d",
                   i, count_sat[4*i +: 4], count_wrap[4*i +: 4], mods[i] - 1);
        end
      end
    end
  end

  initial begin
    int first_done;
    clear  = 1'b1;
    load_n = 1'b1;
    enable = 1'b0;
    data   = '0;
    val[0] = 0; val[1] = 0;
    done_m[0] = 1'b0; done_m[1] = 1'b0;
    #1;
    checkOutput("reset_count", 32'(count_sat), 32'h0);
    checkOutput("reset_cend",  32'(cend_sat),  32'h1);
    checkOutput("reset_done",  32'(done_sat),  32'h0);
    @(negedge clk);
    clear = 1'b0;

    $display("[TB] clear mid-count");
    applyStimulus(1'b1, 16'h0345, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    applyClear();

    $display("[TB] load then single decrement with borrow");
    applyStimulus(1'b1, 16'h1200, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0);

    $display("[TB] reach zero, clear during done pulse");
    applyStimulus(1'b1, 16'h0001, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b1, 16'h0001, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    applyClear();

    $display("[TB] enable at zero: saturate versus wrap");
    applyStimulus(1'b1, 16'h0000, 1'b0);
    repeat (5) applyStimulus(1'b0, 16'h0000, 1'b1);

    $display("[TB] clamped load and load priority");
    applyStimulus(1'b1, 16'h7A9F, 1'b0);
    applyStimulus(1'b1, 16'h0123, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1);

    $display("[TB] full one-minute run");
    applyStimulus(1'b1, 16'h0100, 1'b0);
    first_done = 0;
    for (int i = 1; i <= 70; i++) begin
      applyStimulus(1'b0, 16'h0000, 1'b1);
      @(posedge clk);
      #3;
      if (first_done == 0 && done_sat === 1'b1) first_done = i;
    end
    checkOutput("done_cycle", 32'(first_done), 32'd60);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      bit          ld;
      logic [15:0] d;
      ld = ($urandom_range(0, 9) == 0);
      d  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      applyStimulus(ld, d, ($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    load_n = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #4;
    if (exp_q_sat.size() != 0 || exp_q_wrap.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d/%0d entries left, expected 0",
               exp_q_sat.size(), exp_q_wrap.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
